fp16_recip_dispatch: RTL and testbench
======================================

# fp16_recip_dispatch

Request-side controller for the FP16 reciprocal unit in the vector compute path. It queues tagged FP16 operands from a valid/ready stream and issues them one at a time over the unit's `data`/`data_valid` handshake. It captures the single-cycle `result`/`complete` return and presents results in order on a valid/ready output stream. Special operands are resolved locally without occupying the unit, and a watchdog recovers from a unit that never completes.

## Interface
Parameters:
- `TAG_W`, default 4: width of the sideband tag carried from input to output.
- `FIFO_DEPTH`, default 4: input queue depth; must be a power of 2 and at least 2.
- `TIMEOUT`, default 32: number of cycles spent in WAIT without `rcp_complete` before the request is abandoned.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: input operand valid.
- `in_ready`, output, 1: input queue not full.
- `in_data`, input, 16: FP16 operand.
- `in_tag`, input, TAG_W: operand tag.
- `rcp_data`, output, 16: operand driven to the reciprocal unit.
- `rcp_data_valid`, output, 1: one-cycle issue strobe to the unit.
- `rcp_result`, input, 16: unit result; meaningful only while `rcp_complete` = 1.
- `rcp_complete`, input, 1: one-cycle completion pulse from the unit.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_data`, output, 16: FP16 result.
- `out_tag`, output, TAG_W: tag of the operand that produced the result.
- `out_timeout`, output, 1: set on a result that was abandoned by the watchdog; `out_data` = 0 in that case.
- `busy`, output, 1: high whenever the FSM is not IDLE or the queue is non-empty.

## Operation
- Input queue: a FIFO with depth `FIFO_DEPTH`.
  - Push when `in_valid && in_ready`.
  - `in_ready` = !full.
  - A push and a pop in the same cycle are both legal when the queue is full (net count unchanged) and when it is empty (bypass not required; the entry is stored).
- FSM states: IDLE, ISSUE, WAIT, DRAIN, HOLD.
- IDLE, queue non-empty: classify the head entry.
  - Exp = 0 and mantissa = 0 (±0): result = {sign, 15'h7BFF}, the saturated max finite value. Pop the entry and go to HOLD.
  - Exp = 31, mantissa = 0 (±Inf): result = {sign, 15'h0000}. Pop and go to HOLD.
  - Exp = 31, mantissa ≠ 0 (NaN): result = 16'h7E00. Pop and go to HOLD.
  - Any other value, including subnormals: go to ISSUE.
- ISSUE:
  - `rcp_data` = head entry, `rcp_data_valid` = 1 for exactly this cycle.
  - Pop the entry, latch its tag, clear the watchdog counter, go to WAIT.
- WAIT:
  - `rcp_complete` = 1: capture `rcp_result` into the output register and go to HOLD.
  - Otherwise, if the counter reaches `TIMEOUT`-1: set the output to data 0 with `out_timeout` = 1 and go to DRAIN.
- DRAIN: holds the output valid like HOLD.
  - Once `out_ready` is seen, it also waits for a late `rcp_complete` (which is discarded) or for a further `TIMEOUT` cycles, whichever comes first, then returns to IDLE.
  - `rcp_data_valid` is never asserted while in DRAIN.
- HOLD: `out_valid` = 1. When `out_ready` is seen, go to IDLE.
- `rcp_data` holds its last issued value outside ISSUE; it is 0 after reset.
- `rcp_complete` arriving in any state other than WAIT or DRAIN is ignored.

## Timing
- Reset values: `in_ready` = 1 and `busy` = 0; every other output is 0. Queue empty, FSM in IDLE.
- Reset asserted mid-operation aborts immediately. The reciprocal unit shares `rst`, so no drain is needed after reset.
- Issue rate:
  - The earliest `rcp_data_valid` is 2 cycles after a push into an empty queue: push edge, IDLE, ISSUE.
  - After a result is handed off (HOLD → IDLE), the next issue is at least 2 cycles later. This guarantees the unit has returned to its idle state, which happens on the edge that samples its `complete`.
- Special-operand latency: `out_valid` rises 2 cycles after the push into an empty queue.
- Normal latency: `out_valid` rises 1 cycle after `rcp_complete`.
- Output stability: `out_data`, `out_tag` and `out_timeout` are held stable while `out_valid && !out_ready`.
- Ordering: results leave in strict input order, including bypassed and timed-out entries.

## Structure
- Shared package (`fp16_pkg`):
  - FP16 field positions: sign bit 15, exponent [14:10], mantissa [9:0].
  - Constants `FP16_MAX_FINITE` = 16'h7BFF and `FP16_QNAN` = 16'h7E00.
  - FSM state enum.
- Sub-module `sync_fifo`: parameterised width/depth FIFO with full/empty flags, storing {tag, data}.
- Classification and the watchdog counter are inline in `fp16_recip_dispatch`.

## Test plan
- Push 0x3C00 with tag 3, return 0x3C00 on complete → out 0x3C00, tag 3, `out_timeout` = 0. Push 0x4000, return 0x3800 → out 0x3800.
- Push 0x8000, 0x7C00 and 0x7E01 → outs 0xFBFF, 0x0000 and 0x7E00 in order. `rcp_data_valid` never asserts.
- Hold `out_ready` = 0 for 30 cycles while pushing 6 operands (`FIFO_DEPTH` = 4) → `in_ready` drops after the queue fills. All 6 results drain in order with correct tags once `out_ready` = 1.
- Tie `rcp_complete` = 0 → after 32 WAIT cycles, out 0x0000 with `out_timeout` = 1. No new issue happens until the DRAIN window ends. A late complete during DRAIN produces no output.
- Assert `rst` during WAIT, then release and push 0x4400 → all outputs are 0 during reset, a fresh issue follows, and the result is correct.
- Mixed stream of a special, a normal and a special operand → one `rcp_data_valid` pulse in total, order preserved.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the reciprocal dispatch path: field positions,
// special-value constants, operand classes and the dispatcher FSM states.
package fp16_pkg;

    localparam int FP16_SIGN_BIT = 15;
    localparam int FP16_EXP_MSB  = 14;
    localparam int FP16_EXP_LSB  = 10;
    localparam int FP16_MAN_MSB  = 9;
    localparam int FP16_MAN_LSB  = 0;

    localparam logic [15:0] FP16_MAX_FINITE = 16'h7BFF;
    localparam logic [15:0] FP16_QNAN       = 16'h7E00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_HOLD
    } dispatch_state_t;

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } fp16_class_t;

    // Subnormals count as normal: the reciprocal unit handles them itself.
    function automatic fp16_class_t fp16_classify(input logic [15:0] value);
        logic [4:0] exp_f;
        logic [9:0] man_f;
        fp16_class_t cls;
        exp_f = value[FP16_EXP_MSB:FP16_EXP_LSB];
        man_f = value[FP16_MAN_MSB:FP16_MAN_LSB];
        cls   = CLS_NORMAL;
        if (exp_f == 5'd0 && man_f == 10'd0) begin
            cls = CLS_ZERO;
        end else if (exp_f == 5'h1F) begin
            cls = (man_f == 10'd0) ? CLS_INF : CLS_NAN;
        end
        return cls;
    endfunction

    function automatic logic [15:0] fp16_special_result(input logic [15:0] value);
        logic [15:0] res;
        case (fp16_classify(value))
            CLS_ZERO: res = {value[FP16_SIGN_BIT], FP16_MAX_FINITE[14:0]};
            CLS_INF:  res = {value[FP16_SIGN_BIT], 15'h0000};
            CLS_NAN:  res = FP16_QNAN;
            default:  res = 16'h0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; simultaneous push and pop are
// accepted when full, and an empty-queue push is always stored (no bypass).
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp16_recip_dispatch.sv
// Request-side controller for the FP16 reciprocal unit: queues tagged operands,
// resolves specials locally, issues the rest one at a time and guards with a watchdog.
module fp16_recip_dispatch
    import fp16_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic [15:0]      rcp_data,
    output logic             rcp_data_valid,
    input  logic [15:0]      rcp_result,
    input  logic             rcp_complete,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_timeout,
    output logic             busy
);

    localparam int ENTRY_W = TAG_W + 16;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    dispatch_state_t  state;
    dispatch_state_t  next_state;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [15:0]        head_data;
    logic [TAG_W-1:0]   head_tag;
    fp16_class_t        head_class;

    logic [CNT_W-1:0]   wd_cnt;
    logic               cnt_last;
    logic [15:0]        issued_data;
    logic [TAG_W-1:0]   issue_tag;
    logic               drained;
    logic               late_seen;

    assign fifo_push = in_valid && !fifo_full;
    assign in_ready  = !fifo_full;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({in_tag, in_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_data  = fifo_head[15:0];
    assign head_tag   = fifo_head[ENTRY_W-1:16];
    assign head_class = fp16_classify(head_data);
    assign cnt_last   = (wd_cnt == CNT_LAST);

    assign rcp_data = (state == ST_ISSUE) ? head_data : issued_data;
    assign busy     = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DRAIN has two phases: presenting the timed-out result, then (once handed
    // off) waiting for a stray completion so the unit is idle before reuse.
    always_comb begin
        next_state     = state;
        fifo_pop       = 1'b0;
        rcp_data_valid = 1'b0;
        out_valid      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_class != CLS_NORMAL) begin
                        fifo_pop   = 1'b1;
                        next_state = ST_HOLD;
                    end else begin
                        next_state = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                rcp_data_valid = 1'b1;
                fifo_pop       = 1'b1;
                next_state     = ST_WAIT;
            end
            ST_WAIT: begin
                if (rcp_complete) begin
                    next_state = ST_HOLD;
                end else if (cnt_last) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drained) begin
                    out_valid = 1'b1;
                end else if (late_seen || rcp_complete || cnt_last) begin
                    next_state = ST_IDLE;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output register only changes when a new result is produced, so it stays
    // stable for as long as the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data    <= '0;
            out_tag     <= '0;
            out_timeout <= 1'b0;
            issued_data <= '0;
            issue_tag   <= '0;
            wd_cnt      <= '0;
            drained     <= 1'b0;
            late_seen   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && head_class != CLS_NORMAL) begin
                        out_data    <= fp16_special_result(head_data);
                        out_tag     <= head_tag;
                        out_timeout <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    issued_data <= head_data;
                    issue_tag   <= head_tag;
                    wd_cnt      <= '0;
                end
                ST_WAIT: begin
                    if (rcp_complete) begin
                        out_data    <= rcp_result;
                        out_tag     <= issue_tag;
                        out_timeout <= 1'b0;
                    end else if (cnt_last) begin
                        out_data    <= '0;
                        out_tag     <= issue_tag;
                        out_timeout <= 1'b1;
                        wd_cnt      <= '0;
                        drained     <= 1'b0;
                        late_seen   <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!drained) begin
                        if (rcp_complete) begin
                            late_seen <= 1'b1;
                        end
                        if (out_ready) begin
                            drained <= 1'b1;
                            wd_cnt  <= '0;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_recip_dispatch.sv
// Directed bench for fp16_recip_dispatch with a behavioural reciprocal unit,
// an output collector and hand-computed expected results.
module tb_fp16_recip_dispatch;

    localparam int TAG_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic [15:0]      rcp_data;
    logic             rcp_data_valid;
    logic [15:0]      rcp_result;
    logic             rcp_complete;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_timeout;
    logic             busy;

    logic        resp_complete = 1'b0;
    logic [15:0] resp_result = 16'h0000;
    logic        manual_complete;
    logic        resp_enable;
    int          resp_delay;

    int          checks;
    int          errors;
    int          issue_count = 0;
    logic        saw_full = 1'b0;
    logic [20:0] out_q[$];
    logic [15:0] issue_q[$];

    assign rcp_complete = resp_complete || manual_complete;
    assign rcp_result   = manual_complete ? 16'h1234 : resp_result;

    fp16_recip_dispatch #(
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (4),
        .TIMEOUT    (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_tag         (in_tag),
        .rcp_data       (rcp_data),
        .rcp_data_valid (rcp_data_valid),
        .rcp_result     (rcp_result),
        .rcp_complete   (rcp_complete),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_tag        (out_tag),
        .out_timeout    (out_timeout),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-computed FP16 reciprocals for the operands the bench uses.
    function automatic logic [15:0] refRecip(input logic [15:0] op);
        case (op)
            16'h3C00: return 16'h3C00;
            16'h4000: return 16'h3800;
            16'h4400: return 16'h3400;
            16'h3800: return 16'h4000;
            default:  return 16'h0000;
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) out_q.push_back({out_timeout, out_tag, out_data});
            if (!rst && rcp_data_valid) begin
                issue_count++;
                issue_q.push_back(rcp_data);
            end
            if (!rst && !in_ready) saw_full = 1'b1;
        end
    end

    initial begin
        logic [15:0] op;
        forever begin
            @(negedge clk);
            if (!rst && resp_enable && rcp_data_valid) begin
                op = rcp_data;
                repeat (resp_delay) @(posedge clk);
                @(posedge clk);
                #1;
                resp_complete = 1'b1;
                resp_result   = refRecip(op);
                @(posedge clk);
                #1;
                resp_complete = 1'b0;
                resp_result   = 16'h0000;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] data, input logic [TAG_W-1:0] tag);
        int waited = 0;
        in_data  = data;
        in_tag   = tag;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("push_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResults(input int n, input int budget);
        int waited = 0;
        while (out_q.size() < n && waited < budget) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("result_count", 32'(out_q.size()), 32'(n));
    endtask

    task automatic expectResult(input string name, input logic [15:0] data, input logic [TAG_W-1:0] tag, input logic to);
        logic [20:0] r;
        if (out_q.size() == 0) begin
            checkOutput({name, "_present"}, 32'(out_q.size()), 32'd1);
            return;
        end
        r = out_q.pop_front();
        checkOutput({name, "_data"}, 32'(r[15:0]), 32'(data));
        checkOutput({name, "_tag"}, 32'(r[19:16]), 32'(tag));
        checkOutput({name, "_timeout"}, 32'(r[20]), 32'(to));
    endtask

    task automatic measureIssueToValid(output int n);
        int waited = 0;
        n = 0;
        while (!rcp_data_valid && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("issue_seen", 32'(rcp_data_valid), 32'd1);
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, "_rcp_valid"}, 32'(rcp_data_valid), 32'd0);
        checkOutput({name, "_rcp_data"}, 32'(rcp_data), 32'd0);
        checkOutput({name, "_out_data"}, 32'(out_data), 32'd0);
        checkOutput({name, "_out_tag"}, 32'(out_tag), 32'd0);
        checkOutput({name, "_out_timeout"}, 32'(out_timeout), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: observed running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int n;
        int ic;
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        in_valid        = 1'b0;
        in_data         = 16'h0000;
        in_tag          = '0;
        out_ready       = 1'b1;
        resp_enable     = 1'b1;
        resp_delay      = 0;
        manual_complete = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] normal operands");
        applyStimulus(16'h3C00, 4'd3);
        checkOutput("busy_after_push", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("issue_latency", 32'(rcp_data_valid), 32'd1);
        checkOutput("issue_data", 32'(rcp_data), 32'h3C00);
        waitResults(1, 20);
        expectResult("norm1", 16'h3C00, 4'd3, 1'b0);
        checkOutput("rcp_data_hold", 32'(rcp_data), 32'h3C00);
        applyStimulus(16'h4000, 4'd5);
        measureIssueToValid(n);
        checkOutput("complete_to_valid", 32'(n), 32'd2);
        waitResults(1, 20);
        expectResult("norm2", 16'h3800, 4'd5, 1'b0);

        $display("[TB] special operands");
        ic = issue_count;
        applyStimulus(16'h8000, 4'd1);
        @(posedge clk);
        #1;
        checkOutput("special_latency", 32'(out_valid), 32'd1);
        checkOutput("special_data", 32'(out_data), 32'hFBFF);
        waitResults(1, 20);
        expectResult("neg_zero", 16'hFBFF, 4'd1, 1'b0);
        applyStimulus(16'h7C00, 4'd2);
        applyStimulus(16'h7E01, 4'd4);
        waitResults(2, 20);
        expectResult("pos_inf", 16'h0000, 4'd2, 1'b0);
        expectResult("nan", 16'h7E00, 4'd4, 1'b0);
        checkOutput("special_no_issue", 32'(issue_count), 32'(ic));

        $display("[TB] backpressure");
        ic = issue_count;
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(16'h3C00, 4'd0);
                applyStimulus(16'h8000, 4'd1);
                applyStimulus(16'h4000, 4'd2);
                applyStimulus(16'h7C00, 4'd3);
                applyStimulus(16'h4400, 4'd4);
                applyStimulus(16'h0000, 4'd5);
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitResults(6, 200);
        checkOutput("in_ready_dropped", 32'(saw_full), 32'd1);
        expectResult("bp0", 16'h3C00, 4'd0, 1'b0);
        expectResult("bp1", 16'hFBFF, 4'd1, 1'b0);
        expectResult("bp2", 16'h3800, 4'd2, 1'b0);
        expectResult("bp3", 16'h0000, 4'd3, 1'b0);
        expectResult("bp4", 16'h3400, 4'd4, 1'b0);
        expectResult("bp5", 16'h7BFF, 4'd5, 1'b0);
        checkOutput("bp_issue_count", 32'(issue_count), 32'(ic + 3));

        $display("[TB] watchdog");
        resp_enable = 1'b0;
        ic = issue_count;
        applyStimulus(16'h3800, 4'd7);
        measureIssueToValid(n);
        checkOutput("timeout_latency", 32'(n), 32'd33);
        waitResults(1, 10);
        expectResult("timeout", 16'h0000, 4'd7, 1'b1);
        applyStimulus(16'h3C00, 4'd8);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("drain_no_issue", 32'(issue_count), 32'(ic + 1));
        checkOutput("drain_busy", 32'(busy), 32'd1);
        manual_complete = 1'b1;
        @(posedge clk);
        #1;
        manual_complete = 1'b0;
        resp_enable = 1'b1;
        waitResults(1, 20);
        expectResult("after_drain", 16'h3C00, 4'd8, 1'b0);
        checkOutput("after_drain_issue", 32'(issue_count), 32'(ic + 2));

        $display("[TB] reset during wait");
        resp_enable = 1'b0;
        applyStimulus(16'h4400, 4'd9);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkResetOutputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        resp_enable = 1'b1;
        ic = issue_count;
        applyStimulus(16'h4400, 4'd9);
        waitResults(1, 20);
        expectResult("post_reset", 16'h3400, 4'd9, 1'b0);
        checkOutput("post_reset_issue", 32'(issue_count), 32'(ic + 1));

        $display("[TB] mixed stream");
        ic = issue_count;
        applyStimulus(16'h7C00, 4'd1);
        applyStimulus(16'h4000, 4'd2);
        applyStimulus(16'hFC00, 4'd3);
        waitResults(3, 40);
        expectResult("mix0", 16'h0000, 4'd1, 1'b0);
        expectResult("mix1", 16'h3800, 4'd2, 1'b0);
        expectResult("mix2", 16'h8000, 4'd3, 1'b0);
        checkOutput("mix_issue_count", 32'(issue_count), 32'(ic + 1));
        checkOutput("mix_issue_op", 32'(issue_q[issue_q.size() - 1]), 32'h4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
